// File: rtl/bus_arbiter_nm.sv
// Serial bus arbiter connecting N_MASTERS masters to N_SLAVES slaves. The slave is
// chosen from the leading address bits, and a grant that sees no address bits times out.

module bus_arbiter_nm #(
    parameter int  N_MASTERS = 2,
    parameter int  N_SLAVES  = 3,
    parameter int  SEL_W     = 2,
    parameter int  RR_MODE   = 1,
    parameter int  TIMEOUT   = 16,
    localparam int MID_W     = (N_MASTERS > 2) ? $clog2(N_MASTERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_MASTERS-1:0] m_request,
    input  logic [N_MASTERS-1:0] m_address,
    input  logic [N_MASTERS-1:0] m_data,
    input  logic [N_MASTERS-1:0] m_valid,
    input  logic [N_MASTERS-1:0] m_address_valid,
    input  logic [N_MASTERS-1:0] m_write_en,
    input  logic [N_MASTERS-1:0] m_burst,
    output logic [N_MASTERS-1:0] m_available,
    output logic [N_MASTERS-1:0] m_ready,
    output logic [N_MASTERS-1:0] m_data_out,
    output logic [N_MASTERS-1:0] m_valid_in,
    input  logic [N_SLAVES-1:0]  s_ready,
    input  logic [N_SLAVES-1:0]  s_data_in,
    input  logic [N_SLAVES-1:0]  s_valid_out,
    output logic [N_SLAVES-1:0]  s_address,
    output logic [N_SLAVES-1:0]  s_data,
    output logic [N_SLAVES-1:0]  s_valid,
    output logic [N_SLAVES-1:0]  s_write_en,
    output logic [N_SLAVES-1:0]  s_burst,
    output logic [MID_W-1:0]     grant_id,
    output logic [SEL_W-1:0]     slave_sel,
    output logic                 error,
    output logic [2:0]           state
);

    localparam int CNT_W = $clog2(SEL_W + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [MID_W-1:0] MID_ONE = MID_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_CONNECT = 3'd2,
        ST_ERROR   = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [MID_W-1:0]      grant_r;
    logic [MID_W-1:0]      rr_ptr_r;
    logic [SEL_W-1:0]      sel_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [TO_W-1:0]       to_cnt_r;
    logic [N_MASTERS-1:0]  avail_r;
    logic                  error_r;

    logic [MID_W-1:0]      win_s;
    logic [MID_W-1:0]      rr_nxt_s;
    logic [SEL_W:0]        sel_ext_s;
    logic [SEL_W-1:0]      sel_shift_s;
    logic                  g_req_s;
    logic                  g_addr_s;
    logic                  g_addr_v_s;
    logic                  g_data_s;
    logic                  g_valid_s;
    logic                  g_we_s;
    logic                  g_burst_s;
    logic                  sl_ready_s;
    logic                  sl_data_s;
    logic                  sl_valid_s;

    // Lowest requester overall, or in round-robin mode the lowest one at or above
    // ptr, which is exactly a wrap-around search starting from ptr.
    function automatic logic [MID_W-1:0] pick_winner(input logic [N_MASTERS-1:0] req,
                                                     input logic [MID_W-1:0]     ptr);
        logic [MID_W-1:0] win_any;
        logic [MID_W-1:0] win_hi;
        logic             found_hi;
        win_any  = {MID_W{1'b0}};
        win_hi   = {MID_W{1'b0}};
        found_hi = 1'b0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_any = MID_W'(i);
                if (i >= int'(ptr)) begin
                    win_hi   = MID_W'(i);
                    found_hi = 1'b1;
                end else begin
                    found_hi = found_hi;
                end
            end else begin
                win_any = win_any;
            end
        end
        return ((RR_MODE != 0) && found_hi) ? win_hi : win_any;
    endfunction

    function automatic logic [N_MASTERS-1:0] onehot(input logic [MID_W-1:0] idx);
        logic [N_MASTERS-1:0] v;
        for (int i = 0; i < N_MASTERS; i++) begin
            v[i] = (idx == MID_W'(i));
        end
        return v;
    endfunction

    // Lines of the granted master and the selected slave, plus the arbitration result.
    always_comb begin
        g_req_s     = 1'b0;
        g_addr_s    = 1'b0;
        g_addr_v_s  = 1'b0;
        g_data_s    = 1'b0;
        g_valid_s   = 1'b0;
        g_we_s      = 1'b0;
        g_burst_s   = 1'b0;
        sl_ready_s  = 1'b0;
        sl_data_s   = 1'b0;
        sl_valid_s  = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_r == MID_W'(i)) begin
                g_req_s    = m_request[i];
                g_addr_s   = m_address[i];
                g_addr_v_s = m_address_valid[i];
                g_data_s   = m_data[i];
                g_valid_s  = m_valid[i];
                g_we_s     = m_write_en[i];
                g_burst_s  = m_burst[i];
            end else begin
                g_req_s    = g_req_s;
            end
        end
        for (int j = 0; j < N_SLAVES; j++) begin
            if (sel_r == SEL_W'(j)) begin
                sl_ready_s = s_ready[j];
                sl_data_s  = s_data_in[j];
                sl_valid_s = s_valid_out[j];
            end else begin
                sl_ready_s = sl_ready_s;
            end
        end
        sel_ext_s   = {sel_r, g_addr_s};
        sel_shift_s = sel_ext_s[SEL_W-1:0];
        win_s       = pick_winner(m_request, rr_ptr_r);
        rr_nxt_s    = (win_s == MID_W'(N_MASTERS - 1)) ? {MID_W{1'b0}} : (win_s + MID_ONE);
    end

    // State register and the datapath registers that travel with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            grant_r   <= {MID_W{1'b0}};
            rr_ptr_r  <= {MID_W{1'b0}};
            sel_r     <= {SEL_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            to_cnt_r  <= {TO_W{1'b0}};
            avail_r   <= {N_MASTERS{1'b0}};
            error_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            error_r <= (state_nxt_s == ST_ERROR);
            if ((state_nxt_s == ST_GRANT) || (state_nxt_s == ST_CONNECT)) begin
                avail_r <= (state_r == ST_IDLE) ? onehot(win_s) : onehot(grant_r);
            end else begin
                avail_r <= {N_MASTERS{1'b0}};
            end
            case (state_r)
                ST_IDLE: begin
                    if (state_nxt_s == ST_GRANT) begin
                        grant_r   <= win_s;
                        rr_ptr_r  <= rr_nxt_s;
                        sel_r     <= {SEL_W{1'b0}};
                        bit_cnt_r <= {CNT_W{1'b0}};
                        to_cnt_r  <= {TO_W{1'b0}};
                    end else begin
                        grant_r   <= grant_r;
                    end
                end
                ST_GRANT: begin
                    if (g_addr_v_s) begin
                        sel_r     <= sel_shift_s;
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        to_cnt_r  <= {TO_W{1'b0}};
                    end else begin
                        to_cnt_r  <= to_cnt_r + TO_ONE;
                    end
                end
                default: begin
                    grant_r <= grant_r;
                end
            endcase
        end
    end

    // Next-state logic; a dropped request always wins over a pending address bit.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|m_request) begin
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!g_req_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (g_addr_v_s) begin
                    if (bit_cnt_r == CNT_W'(SEL_W - 1)) begin
                        state_nxt_s = (int'(sel_shift_s) < N_SLAVES) ? ST_CONNECT : ST_ERROR;
                    end else begin
                        state_nxt_s = ST_GRANT;
                    end
                end else if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            ST_CONNECT: begin
                if (!g_req_s) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_CONNECT;
                end
            end
            ST_ERROR: begin
                state_nxt_s = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!g_req_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Zero-latency pass-through between the granted master and the selected slave.
    always_comb begin
        s_address  = {N_SLAVES{1'b0}};
        s_data     = {N_SLAVES{1'b0}};
        s_valid    = {N_SLAVES{1'b0}};
        s_write_en = {N_SLAVES{1'b0}};
        s_burst    = {N_SLAVES{1'b0}};
        m_ready    = {N_MASTERS{1'b0}};
        m_data_out = {N_MASTERS{1'b0}};
        m_valid_in = {N_MASTERS{1'b0}};
        if (state_r == ST_CONNECT) begin
            for (int j = 0; j < N_SLAVES; j++) begin
                if (sel_r == SEL_W'(j)) begin
                    s_address[j]  = g_addr_s;
                    s_data[j]     = g_data_s;
                    s_valid[j]    = g_valid_s | g_addr_v_s;
                    s_write_en[j] = g_we_s;
                    s_burst[j]    = g_burst_s;
                end else begin
                    s_address[j]  = 1'b0;
                end
            end
            for (int i = 0; i < N_MASTERS; i++) begin
                if (grant_r == MID_W'(i)) begin
                    m_ready[i]    = sl_ready_s;
                    m_data_out[i] = sl_data_s;
                    m_valid_in[i] = sl_valid_s;
                end else begin
                    m_ready[i]    = 1'b0;
                end
            end
        end else begin
            s_address = {N_SLAVES{1'b0}};
        end
    end

    assign m_available = avail_r;
    assign grant_id    = grant_r;
    assign slave_sel   = sel_r;
    assign error       = error_r;
    assign state       = state_r;

endmodule

// File: tb/tb_bus_arbiter_nm.sv
// Directed scoreboard bench for bus_arbiter_nm: a round-robin instance plus a
// fixed-priority instance driven by the same inputs.

module tb_bus_arbiter_nm;

    localparam int NM = 2;
    localparam int NS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [NM-1:0] m_request, m_address, m_data, m_valid, m_address_valid, m_write_en, m_burst;
    logic [NS-1:0] s_ready, s_data_in, s_valid_out;

    logic [NM-1:0] m_available, m_ready, m_data_out, m_valid_in;
    logic [NS-1:0] s_address, s_data, s_valid, s_write_en, s_burst;
    logic [0:0]    grant_id;
    logic [1:0]    slave_sel;
    logic          error;
    logic [2:0]    state;

    logic [NM-1:0] fp_m_available, fp_m_ready, fp_m_data_out, fp_m_valid_in;
    logic [NS-1:0] fp_s_address, fp_s_data, fp_s_valid, fp_s_write_en, fp_s_burst;
    logic [0:0]    fp_grant_id;
    logic [1:0]    fp_slave_sel;
    logic          fp_error;
    logic [2:0]    fp_state;

    bus_arbiter_nm #(.N_MASTERS(NM), .N_SLAVES(NS), .SEL_W(2), .RR_MODE(1), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .m_request(m_request), .m_address(m_address),
        .m_data(m_data), .m_valid(m_valid), .m_address_valid(m_address_valid),
        .m_write_en(m_write_en), .m_burst(m_burst), .m_available(m_available),
        .m_ready(m_ready), .m_data_out(m_data_out), .m_valid_in(m_valid_in),
        .s_ready(s_ready), .s_data_in(s_data_in), .s_valid_out(s_valid_out),
        .s_address(s_address), .s_data(s_data), .s_valid(s_valid),
        .s_write_en(s_write_en), .s_burst(s_burst), .grant_id(grant_id),
        .slave_sel(slave_sel), .error(error), .state(state)
    );

    bus_arbiter_nm #(.N_MASTERS(NM), .N_SLAVES(NS), .SEL_W(2), .RR_MODE(0), .TIMEOUT(16)) dut_fp (
        .clk(clk), .reset(reset), .m_request(m_request), .m_address(m_address),
        .m_data(m_data), .m_valid(m_valid), .m_address_valid(m_address_valid),
        .m_write_en(m_write_en), .m_burst(m_burst), .m_available(fp_m_available),
        .m_ready(fp_m_ready), .m_data_out(fp_m_data_out), .m_valid_in(fp_m_valid_in),
        .s_ready(s_ready), .s_data_in(s_data_in), .s_valid_out(s_valid_out),
        .s_address(fp_s_address), .s_data(fp_s_data), .s_valid(fp_s_valid),
        .s_write_en(fp_s_write_en), .s_burst(fp_s_burst), .grant_id(fp_grant_id),
        .slave_sel(fp_slave_sel), .error(fp_error), .state(fp_state)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_ptr;
    logic [10:0] pat;

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%0h expected=<queued value>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        m_request = 2'b00; m_address = 2'b00; m_data = 2'b00; m_valid = 2'b00;
        m_address_valid = 2'b00; m_write_en = 2'b00; m_burst = 2'b00;
        s_ready = 3'b000; s_data_in = 3'b000; s_valid_out = 3'b000;
        pat = 11'b10110011101;

        // Reset state
        sb_push("rst_state", 32'd0); sb_push("rst_avail", 32'd0); sb_push("rst_gid", 32'd0);
        sb_push("rst_sel", 32'd0); sb_push("rst_error", 32'd0); sb_push("rst_svalid", 32'd0);
        step(); step();
        sb_check(32'(state)); sb_check(32'(m_available)); sb_check(32'(grant_id));
        sb_check(32'(slave_sel)); sb_check(32'(error)); sb_check(32'(s_valid));
        reset = 1'b0;
        model_ptr = 0;
        step();

        // Master 0 grant, address 1,0 selects slave 2, payload bits on s_address[2] only
        m_request = 2'b01;
        sb_push("t1_state", 32'd1); sb_push("t1_avail", 32'd1); sb_push("t1_gid", 32'd0);
        step();
        sb_check(32'(state)); sb_check(32'(m_available)); sb_check(32'(grant_id));
        model_ptr = 1;
        m_address_valid = 2'b01; m_address = 2'b01;
        sb_push("t1_bit1_state", 32'd1);
        step();
        sb_check(32'(state));
        m_address = 2'b00;
        sb_push("t1_conn_state", 32'd2); sb_push("t1_sel", 32'd2);
        step();
        sb_check(32'(state)); sb_check(32'(slave_sel));
        for (int k = 0; k < 11; k++) begin
            m_address[0] = pat[k];
            sb_push("t1_saddr", {29'd0, pat[k], 2'b00});
            #1;
            sb_check(32'(s_address));
            step();
        end
        m_address_valid = 2'b00; m_address = 2'b00; m_request = 2'b00;
        sb_push("t1_rel_state", 32'd4); sb_push("t1_rel_avail", 32'd0);
        step();
        sb_check(32'(state)); sb_check(32'(m_available));
        sb_push("t1_idle", 32'd0);
        step();
        sb_check(32'(state));

        // Master 1 write/read on slave 1 with zero-latency paths
        m_request = 2'b10;
        sb_push("t2_gid", 32'd1); sb_push("t2_avail", 32'd2);
        step();
        sb_check(32'(grant_id)); sb_check(32'(m_available));
        model_ptr = 0;
        m_address_valid = 2'b10; m_address = 2'b00;
        step();
        m_address = 2'b10;
        sb_push("t2_state", 32'd2); sb_push("t2_sel", 32'd1);
        step();
        sb_check(32'(state)); sb_check(32'(slave_sel));
        m_address_valid = 2'b00; m_address = 2'b00;
        m_data = 2'b10; m_valid = 2'b10; m_write_en = 2'b10; m_burst = 2'b10;
        sb_push("t2_sdata", 32'd2); sb_push("t2_svalid", 32'd2);
        sb_push("t2_swe", 32'd2); sb_push("t2_sburst", 32'd2);
        #1;
        sb_check(32'(s_data)); sb_check(32'(s_valid));
        sb_check(32'(s_write_en)); sb_check(32'(s_burst));
        m_data = 2'b00;
        sb_push("t2_sdata0", 32'd0);
        #1;
        sb_check(32'(s_data));
        m_valid = 2'b00; m_write_en = 2'b00; m_burst = 2'b00;
        s_data_in = 3'b011; s_valid_out = 3'b010; s_ready = 3'b010;
        sb_push("t2_mdout", 32'd2); sb_push("t2_mvin", 32'd2); sb_push("t2_mrdy", 32'd2);
        #1;
        sb_check(32'(m_data_out)); sb_check(32'(m_valid_in)); sb_check(32'(m_ready));
        s_data_in = 3'b001;
        sb_push("t2_mdout_unsel", 32'd0);
        #1;
        sb_check(32'(m_data_out));
        s_ready = 3'b000;
        sb_push("t2_mrdy0", 32'd0);
        #1;
        sb_check(32'(m_ready));
        s_data_in = 3'b000; s_valid_out = 3'b000;
        m_request = 2'b00;
        step();
        sb_push("t2_idle", 32'd0);
        step();
        sb_check(32'(state));

        // Both masters requesting: round-robin alternates, fixed priority keeps master 0
        for (int t = 0; t < 3; t++) begin
            m_request = 2'b11;
            sb_push("t3_rr_gid", 32'(model_ptr)); sb_push("t3_fp_gid", 32'd0);
            sb_push("t3_rr_avail", 32'(1 << model_ptr)); sb_push("t3_fp_avail", 32'd1);
            step();
            sb_check(32'(grant_id)); sb_check(32'(fp_grant_id));
            sb_check(32'(m_available)); sb_check(32'(fp_m_available));
            model_ptr = (model_ptr + 1) % NM;
            m_request = 2'b00;
            sb_push("t3_idle", 32'd0); sb_push("t3_fp_idle", 32'd0);
            step();
            sb_check(32'(state)); sb_check(32'(fp_state));
        end

        // Address prefix 11 is out of range: error pulse, ERROR then RELEASE
        m_request = 2'b01;
        sb_push("t4_gid", 32'd0);
        step();
        sb_check(32'(grant_id));
        model_ptr = 1;
        m_address_valid = 2'b01; m_address = 2'b01; m_valid = 2'b01;
        step();
        sb_push("t4_state", 32'd3); sb_push("t4_error", 32'd1);
        sb_push("t4_avail", 32'd0); sb_push("t4_svalid", 32'd0);
        step();
        sb_check(32'(state)); sb_check(32'(error));
        sb_check(32'(m_available)); sb_check(32'(s_valid));
        m_address_valid = 2'b00; m_address = 2'b00; m_valid = 2'b00;
        sb_push("t4_rel_state", 32'd4); sb_push("t4_rel_error", 32'd0);
        step();
        sb_check(32'(state)); sb_check(32'(error));
        sb_push("t4_hold_state", 32'd4);
        step();
        sb_check(32'(state));
        m_request = 2'b00;
        sb_push("t4_idle", 32'd0);
        step();
        sb_check(32'(state));

        // Timeout: 16 grant cycles without an address bit
        m_request = 2'b01;
        sb_push("t5_state", 32'd1);
        step();
        sb_check(32'(state));
        repeat (14) step();
        sb_push("t5_pre_state", 32'd1); sb_push("t5_pre_avail", 32'd1);
        step();
        sb_check(32'(state)); sb_check(32'(m_available));
        sb_push("t5_to_state", 32'd3); sb_push("t5_to_error", 32'd1); sb_push("t5_to_avail", 32'd0);
        step();
        sb_check(32'(state)); sb_check(32'(error)); sb_check(32'(m_available));
        m_request = 2'b00;
        sb_push("t5_rel_state", 32'd4);
        step();
        sb_check(32'(state));
        sb_push("t5_idle", 32'd0);
        step();
        sb_check(32'(state));

        // Reset in the middle of CONNECT, then the pointer must restart at master 0
        m_request = 2'b01;
        step();
        m_address_valid = 2'b01; m_address = 2'b00;
        step();
        m_address = 2'b01;
        sb_push("t6_state", 32'd2);
        step();
        sb_check(32'(state));
        m_address_valid = 2'b00; m_address = 2'b00;
        m_valid = 2'b01; m_data = 2'b01; s_data_in = 3'b010; s_valid_out = 3'b010;
        sb_push("t6_svalid", 32'd2); sb_push("t6_mdout", 32'd1);
        #1;
        sb_check(32'(s_valid)); sb_check(32'(m_data_out));
        reset = 1'b1;
        sb_push("t6_rst_state", 32'd0); sb_push("t6_rst_avail", 32'd0);
        sb_push("t6_rst_gid", 32'd0); sb_push("t6_rst_sel", 32'd0);
        sb_push("t6_rst_error", 32'd0); sb_push("t6_rst_svalid", 32'd0);
        sb_push("t6_rst_sdata", 32'd0); sb_push("t6_rst_mdout", 32'd0);
        sb_push("t6_rst_mvin", 32'd0);
        step();
        sb_check(32'(state)); sb_check(32'(m_available));
        sb_check(32'(grant_id)); sb_check(32'(slave_sel));
        sb_check(32'(error)); sb_check(32'(s_valid));
        sb_check(32'(s_data)); sb_check(32'(m_data_out));
        sb_check(32'(m_valid_in));
        reset = 1'b0;
        m_request = 2'b11; m_valid = 2'b00; m_data = 2'b00;
        s_data_in = 3'b000; s_valid_out = 3'b000;
        sb_push("t6_post_gid", 32'd0); sb_push("t6_post_avail", 32'd1); sb_push("t6_post_state", 32'd1);
        step();
        sb_check(32'(grant_id)); sb_check(32'(m_available)); sb_check(32'(state));
        m_request = 2'b00;
        step();

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
